// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq -- program-counter command sequencer.
//
// Issues one PC command per cycle (inc / add / sub with offset) and
// arbitrates between two branch requesters: requester 0 is the branch unit
// and requester 1 is the exception unit. A granted branch produces one
// BRANCH cycle followed by BR_PENALTY bubble cycles, then fetch resumes.
//
// Optional feature macro: PC_SEQ_RR_EN
//   defined   -> round-robin arbitration with a one-bit preference pointer
//   undefined -> fixed priority, requester 1 always wins, no pointer state
//
// Parameter
//   BR_PENALTY  bubble cycles after each branch (0..7)
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-low reset
//   run        in   level, enables sequential fetch
//   halt       in   level, pauses PC activity while in FETCH/HALTED
//   req_valid  in   [1:0] per-requester branch request
//   req_sub    in   [1:0] per-requester direction (1 = subtract)
//   req_off0   in   [15:0] branch offset of requester 0
//   req_off1   in   [15:0] branch offset of requester 1
//   req_ready  out  [1:0] per-requester grant
//   inc        out  PC increment command
//   add        out  PC add-offset command
//   sub        out  PC subtract-offset command
//   offset     out  [15:0] offset for add/sub, zero otherwise
//   state      out  [2:0] IDLE=0 FETCH=1 BRANCH=2 BUBBLE=3 HALTED=4
// ---------------------------------------------------------------------------
module pc_seq #(
  parameter int unsigned BR_PENALTY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_sub,
  input  logic [15:0] req_off0,
  input  logic [15:0] req_off1,
  output logic [1:0]  req_ready,
  output logic        inc,
  output logic        add,
  output logic        sub,
  output logic [15:0] offset,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_BRANCH = 3'd2,
    S_BUBBLE = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  // The counter is loaded with BR_PENALTY-1 so that BUBBLE spans exactly
  // BR_PENALTY cycles, leaving on the cycle it reads zero.
  localparam logic [2:0] BUB_LOAD = (BR_PENALTY > 0) ? 3'(BR_PENALTY - 1) : 3'd0;

  state_t      state_reg, state_next;
  logic [2:0]  bub_cnt_reg, bub_cnt_next;
  logic [15:0] off_reg;
  logic        dir_reg;
  logic [1:0]  grant;
  logic        xfer;
  logic        gidx;

`ifdef PC_SEQ_RR_EN
  logic        ptr_reg;
`endif

  // Arbiter: grants only in FETCH with run=1 and halt=0, never to an
  // idle requester, so any grant bit implies a transfer this cycle.
  always_comb begin
    grant = 2'b00;
    if (state_reg == S_FETCH && run && !halt) begin
`ifdef PC_SEQ_RR_EN
      if (req_valid[ptr_reg])
        grant[ptr_reg] = 1'b1;
      else if (req_valid[~ptr_reg])
        grant[~ptr_reg] = 1'b1;
`else
      if (req_valid[1])
        grant = 2'b10;
      else if (req_valid[0])
        grant = 2'b01;
`endif
    end
  end

  assign xfer = |(req_valid & grant);
  assign gidx = grant[1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      bub_cnt_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      bub_cnt_reg <= bub_cnt_next;
    end
  end

  // Captured branch request plus the round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_reg <= 16'h0000;
      dir_reg <= 1'b0;
`ifdef PC_SEQ_RR_EN
      ptr_reg <= 1'b0;
`endif
    end else if (xfer) begin
      off_reg <= gidx ? req_off1 : req_off0;
      dir_reg <= req_sub[gidx];
`ifdef PC_SEQ_RR_EN
      ptr_reg <= ~gidx;
`endif
    end
  end

  // Next-state logic. run/halt are deliberately not looked at in BRANCH
  // and BUBBLE; they take effect once FETCH is re-entered.
  always_comb begin
    state_next   = state_reg;
    bub_cnt_next = bub_cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (!run)      state_next = S_IDLE;
        else if (halt) state_next = S_HALTED;
        else if (xfer) state_next = S_BRANCH;
      end
      S_BRANCH: begin
        if (BR_PENALTY > 0) begin
          state_next   = S_BUBBLE;
          bub_cnt_next = BUB_LOAD;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_BUBBLE: begin
        if (bub_cnt_reg == 3'd0) state_next = S_FETCH;
        else                     bub_cnt_next = bub_cnt_reg - 3'd1;
      end
      S_HALTED: begin
        if (!run)      state_next = S_IDLE;
        else if (!halt) state_next = S_FETCH;
      end
      default: begin
        state_next   = S_IDLE;
        bub_cnt_next = 3'd0;
      end
    endcase
  end

  // Output logic: commands depend on state only, so reset clears them
  // immediately through the asynchronously cleared state register.
  always_comb begin
    inc       = 1'b0;
    add       = 1'b0;
    sub       = 1'b0;
    offset    = 16'h0000;
    req_ready = grant;
    state     = state_reg;
    case (state_reg)
      S_FETCH:  inc = 1'b1;
      S_BRANCH: begin
        add    = ~dir_reg;
        sub    = dir_reg;
        offset = off_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_seq -- self-checking bench for pc_seq.
// Three instances share stimulus: BR_PENALTY = 1 (default), 0 and 3.
// A vector table drives the default instance; hand-written sequences cover
// arbitration, zero-penalty branching, bubble length and reset mid-bubble.
// ---------------------------------------------------------------------------
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_sub = 2'b00;
  logic [15:0] req_off0 = 16'h0000;
  logic [15:0] req_off1 = 16'h0000;

  logic [1:0]  rdy1, rdy0, rdy3;
  logic        inc1, add1, sub1, inc0, add0, sub0, inc3, add3, sub3;
  logic [15:0] off1, off0, off3;
  logic [2:0]  st1, st0, st3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_seq u_p1 (
    .clk(clk), .reset(rst_n), .run(run), .halt(halt),
    .req_valid(req_valid), .req_sub(req_sub),
    .req_off0(req_off0), .req_off1(req_off1),
    .req_ready(rdy1), .inc(inc1), .add(add1), .sub(sub1),
    .offset(off1), .state(st1)
  );

  pc_seq #(.BR_PENALTY(0)) u_p0 (
    .clk(clk), .reset(rst_n), .run(run), .halt(halt),
    .req_valid(req_valid), .req_sub(req_sub),
    .req_off0(req_off0), .req_off1(req_off1),
    .req_ready(rdy0), .inc(inc0), .add(add0), .sub(sub0),
    .offset(off0), .state(st0)
  );

  pc_seq #(.BR_PENALTY(3)) u_p3 (
    .clk(clk), .reset(rst_n), .run(run), .halt(halt),
    .req_valid(req_valid), .req_sub(req_sub),
    .req_off0(req_off0), .req_off1(req_off1),
    .req_ready(rdy3), .inc(inc3), .add(add3), .sub(sub3),
    .offset(off3), .state(st3)
  );

  typedef struct {
    logic        run;
    logic        halt;
    logic [1:0]  valid;
    logic [1:0]  sub;
    logic [15:0] off0;
    logic [15:0] off1;
    logic [2:0]  e_state;
    logic        e_inc;
    logic        e_add;
    logic        e_sub;
    logic [15:0] e_off;
    logic [1:0]  e_rdy;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic r, input logic h, input logic [1:0] v,
                         input logic [1:0] s, input logic [15:0] o0,
                         input logic [15:0] o1, input logic [2:0] st,
                         input logic i, input logic a, input logic sb,
                         input logic [15:0] off, input logic [1:0] rdy);
    vec_t t;
    t.run = r; t.halt = h; t.valid = v; t.sub = s; t.off0 = o0; t.off1 = o1;
    t.e_state = st; t.e_inc = i; t.e_add = a; t.e_sub = sb;
    t.e_off = off; t.e_rdy = rdy;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse reset between clock edges and release it on a falling edge.
  task automatic do_reset();
    run = 1'b0; halt = 1'b0; req_valid = 2'b00; req_sub = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pk(input logic [2:0] st, input logic i,
                                     input logic a, input logic sb,
                                     input logic [15:0] off,
                                     input logic [1:0] rdy);
    return {8'h00, st, i, a, sb, off, rdy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] grants[4];
    logic [1:0] exp_g[4];
    int         ng;
    int         nb;
    logic [1:0] last_g;

    // Vector table: inputs applied after the falling edge, outputs checked
    // 1 time unit later (state is the value before the next rising edge).
    //       run halt valid sub   off0      off1      st  inc add sub off      rdy
    add_vec(0, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b01, 2'b00, 16'h0010, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b01);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0010, 16'h0000, 2, 0, 1, 0, 16'h0010, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0010, 16'h0000, 3, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h0010, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 1, 2'b01, 2'b00, 16'h1234, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 1, 2'b01, 2'b00, 16'h1234, 16'h0000, 4, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b01, 2'b00, 16'h1234, 16'h0000, 4, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b01, 2'b00, 16'h1234, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b01);
    add_vec(1, 0, 2'b00, 2'b00, 16'h1234, 16'h0000, 2, 0, 1, 0, 16'h1234, 2'b00);
    add_vec(0, 1, 2'b00, 2'b00, 16'h1234, 16'h0000, 3, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(0, 0, 2'b10, 2'b00, 16'h1234, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(0, 0, 2'b00, 2'b00, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 0, 2'b10, 2'b10, 16'h1234, 16'h8000, 1, 1, 0, 0, 16'h0000, 2'b10);
    add_vec(1, 0, 2'b00, 2'b10, 16'h1234, 16'h8000, 2, 0, 0, 1, 16'h8000, 2'b00);
    add_vec(1, 0, 2'b00, 2'b00, 16'h1234, 16'h8000, 3, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(1, 1, 2'b00, 2'b00, 16'h1234, 16'h8000, 1, 1, 0, 0, 16'h0000, 2'b00);
    add_vec(0, 1, 2'b00, 2'b00, 16'h1234, 16'h8000, 4, 0, 0, 0, 16'h0000, 2'b00);
    add_vec(0, 0, 2'b00, 2'b00, 16'h1234, 16'h8000, 0, 0, 0, 0, 16'h0000, 2'b00);

    // Reset state, checked before any clock edge.
    #1;
    check("reset_p1", pk(st1, inc1, add1, sub1, off1, rdy1), 32'h0);
    check("reset_p0", pk(st0, inc0, add0, sub0, off0, rdy0), 32'h0);
    check("reset_p3", pk(st3, inc3, add3, sub3, off3, rdy3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      run = vq[k].run; halt = vq[k].halt; req_valid = vq[k].valid;
      req_sub = vq[k].sub; req_off0 = vq[k].off0; req_off1 = vq[k].off1;
      #1;
      check($sformatf("vec%0d", k), pk(st1, inc1, add1, sub1, off1, rdy1),
            pk(vq[k].e_state, vq[k].e_inc, vq[k].e_add, vq[k].e_sub,
               vq[k].e_off, vq[k].e_rdy));
      tick();
    end

    // Arbitration with both requesters continuously valid.
`ifdef PC_SEQ_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
    do_reset();
    run = 1'b1; req_valid = 2'b11; req_sub = 2'b00;
    req_off0 = 16'h0001; req_off1 = 16'h0002;
    ng = 0; last_g = 2'b00;
    tick();
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (st1 == 3'd2)
        check($sformatf("arb_branch_off%0d", ng - 1), {16'h0, off1},
              {16'h0, (last_g == 2'b10) ? 16'h0002 : 16'h0001});
      if (rdy1 != 2'b00) begin
        grants[ng] = rdy1;
        last_g = rdy1;
        ng++;
      end
      tick();
    end
    if (ng < 4) check("arb_timeout", ng, 4);
    for (int g = 0; g < ng; g++)
      check($sformatf("arb_grant%0d", g), {30'h0, grants[g]}, {30'h0, exp_g[g]});
    req_valid = 2'b00;

    // Zero-penalty subtract branch of 16'hFFFF.
    do_reset();
    run = 1'b1;
    tick();
    req_valid = 2'b01; req_sub = 2'b01; req_off0 = 16'hFFFF;
    #1;
    check("p0_ready", {30'h0, rdy0}, 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("p0_branch", pk(st0, inc0, add0, sub0, off0, rdy0),
          pk(3'd2, 1'b0, 1'b0, 1'b1, 16'hFFFF, 2'b00));
    tick();
    #1;
    check("p0_resume", pk(st0, inc0, add0, sub0, off0, rdy0),
          pk(3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00));

    // Penalty 3: bubble length, then reset during a bubble.
    do_reset();
    run = 1'b1;
    tick();
    req_valid = 2'b01; req_sub = 2'b00; req_off0 = 16'h0005;
    #1;
    check("p3_ready", {30'h0, rdy3}, 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("p3_branch", pk(st3, inc3, add3, sub3, off3, rdy3),
          pk(3'd2, 1'b0, 1'b1, 1'b0, 16'h0005, 2'b00));
    tick();
    nb = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (st3 != 3'd3) break;
      check($sformatf("p3_bubble%0d", nb), pk(st3, inc3, add3, sub3, off3, rdy3),
            pk(3'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00));
      nb++;
      tick();
    end
    check("p3_bubble_len", nb, 3);
    check("p3_resume", pk(st3, inc3, add3, sub3, off3, rdy3),
          pk(3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00));

    req_valid = 2'b01; req_off0 = 16'h0007;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    check("p3_mid_bubble", {29'h0, st3}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("p3_async_reset", pk(st3, inc3, add3, sub3, off3, rdy3), 32'h0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("p3_post_reset%0d", c), pk(st3, inc3, add3, sub3, off3, rdy3),
            32'h0);
      tick();
    end
    run = 1'b1;
    #1;
    check("p3_idle_run", {29'h0, st3}, 32'd0);
    tick();
    #1;
    check("p3_fetch_run", pk(st3, inc3, add3, sub3, off3, rdy3),
          pk(3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
